bcd2bin: RTL and testbench

BCD2BIN -- requirements
Module: bcd2bin

---
 rtl/bcd2bin.sv | 118 +++++++++++
 tb/tb_bcd2bin.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin.sv
// Three-digit BCD to binary converter: one digit per cycle, accumulator = acc*10 + digit.
// Compile option BCD2BIN_SATURATE_EN: an overflowed result saturates to all ones instead of wrapping.
module bcd2bin #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      din0,
    input  logic [3:0]      din1,
    input  logic [3:0]      din2,
    output logic [BITS-1:0] bin,
    output logic            ready,
    output logic            hiba
);

    localparam int AW = BITS + 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [3:0]      dig2, dig1, dig0;
    logic [AW-1:0]   acc, acc_next;
    logic [1:0]      cnt;
    logic [3:0]      cur_digit;
    logic            bad_digit;
    logic            overflow;
    logic [BITS-1:0] res_bin;
    logic            res_hiba;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (cnt == 2'd2) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Hundreds first, then tens, then ones; x10 built from two shifts.
    always_comb begin
        cur_digit = dig0;
        unique case (cnt)
            2'd0:    cur_digit = dig2;
            2'd1:    cur_digit = dig1;
            default: cur_digit = dig0;
        endcase
        acc_next  = (acc << 3) + (acc << 1) + AW'(cur_digit);
        bad_digit = (dig2 > 4'd9) || (dig1 > 4'd9) || (dig0 > 4'd9);
        overflow  = |acc_next[AW-1:BITS];
    end

    // An invalid digit wins over overflow in both builds.
    always_comb begin
        res_bin  = acc_next[BITS-1:0];
        res_hiba = 1'b0;
        if (bad_digit) begin
            res_bin  = '0;
            res_hiba = 1'b1;
        end else if (overflow) begin
            res_hiba = 1'b1;
`ifdef BCD2BIN_SATURATE_EN
            res_bin  = '1;
`else
            res_bin  = acc_next[BITS-1:0];
`endif
        end
    end

    // NOTE: the digit latches are only a few flops, so they are reset along with everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig2 <= '0;
            dig1 <= '0;
            dig0 <= '0;
            acc  <= '0;
            cnt  <= '0;
            bin  <= '0;
            hiba <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dig2 <= din2;
                        dig1 <= din1;
                        dig0 <= din0;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                CONV: begin
                    acc <= acc_next;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd2) begin
                        bin  <= res_bin;
                        hiba <= res_hiba;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == DONE);

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: directed corner cases, back-to-back starts, mid-conversion reset
// and randomized digit triples compared against an arithmetic reference model.
module tb_bcd2bin;

    localparam int BITS = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [3:0]      din0, din1, din2;
    logic [BITS-1:0] bin;
    logic            ready;
    logic            hiba;

    int              vectors     = 0;
    int              miscompares = 0;
    int              cyc         = 0;
    logic [BITS-1:0] last_bin;
    logic            last_hiba;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bcd2bin #(.BITS(BITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din0  (din0),
        .din1  (din1),
        .din2  (din2),
        .bin   (bin),
        .ready (ready),
        .hiba  (hiba)
    );

    // Reference: decimal value from plain arithmetic, then the error / overflow rules.
    function automatic void model(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                                  output logic [BITS-1:0] b, output logic e);
        int v;
        int maxv;
        v    = h * 100 + t * 10 + o;
        maxv = (1 << BITS) - 1;
        if (h > 9 || t > 9 || o > 9) begin
            b = '0;
            e = 1'b1;
        end else if (v > maxv) begin
            e = 1'b1;
`ifdef BCD2BIN_SATURATE_EN
            b = '1;
`else
            b = BITS'(v % (maxv + 1));
`endif
        end else begin
            b = BITS'(v);
            e = 1'b0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rand_digit();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    // Called one time unit after a rising edge with the FSM idle.
    task automatic convert(input string tag, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        logic [BITS-1:0] eb;
        logic            eh;
        int              lat;
        bit              seen;
        model(h, t, o, eb, eh);
        din2  = h;
        din1  = t;
        din0  = o;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        din2  = rand_digit();
        din1  = rand_digit();
        din0  = rand_digit();
        check({tag, "_hold_bin"}, 32'(bin), 32'(last_bin));
        check({tag, "_hold_hiba"}, 32'(hiba), 32'(last_hiba));
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            @(posedge clk);
            lat++;
            #1;
            if (ready) seen = 1'b1;
        end
        check({tag, "_latency"}, seen ? 32'(lat) : 32'd0, 32'd4);
        check({tag, "_bin"}, 32'(bin), 32'(eb));
        check({tag, "_hiba"}, 32'(hiba), 32'(eh));
        @(posedge clk);
        #1;
        check({tag, "_ready_strobe"}, 32'(ready), 32'd0);
        last_bin  = eb;
        last_hiba = eh;
    endtask

    initial begin
        logic [3:0]      h, t, o;
        logic [3:0]      seq_h[3], seq_t[3], seq_o[3];
        logic [BITS-1:0] eb;
        logic            eh;
        int              last_ready_cyc;
        bit              saw;

        rst       = 1'b1;
        start     = 1'b0;
        din0      = 4'd0;
        din1      = 4'd0;
        din2      = 4'd0;
        last_bin  = '0;
        last_hiba = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_bin", 32'(bin), 32'd0);
        check("reset_hiba", 32'(hiba), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        convert("basic_123", 4'd1, 4'd2, 4'd3);
        convert("max_255", 4'd2, 4'd5, 4'd5);
        convert("zero_000", 4'd0, 4'd0, 4'd0);
        convert("ovf_256", 4'd2, 4'd5, 4'd6);
        convert("ovf_999", 4'd9, 4'd9, 4'd9);
        convert("bad_tens", 4'd0, 4'hA, 4'd0);
        convert("bad_ones", 4'd1, 4'd0, 4'hF);

        // Start held high: capture every 5 cycles, digits scrambled right after each capture.
        seq_h = '{4'd0, 4'd1, 4'd3};
        seq_t = '{4'd4, 4'd9, 4'd0};
        seq_o = '{4'd2, 4'd9, 4'd7};
        last_ready_cyc = 0;
        start = 1'b1;
        for (int j = 0; j < 3; j++) begin
            din2 = seq_h[j];
            din1 = seq_t[j];
            din0 = seq_o[j];
            model(seq_h[j], seq_t[j], seq_o[j], eb, eh);
            @(posedge clk);
            #1;
            din2 = rand_digit();
            din1 = rand_digit();
            din0 = rand_digit();
            repeat (3) @(posedge clk);
            #1;
            check("b2b_ready", 32'(ready), 32'd1);
            check("b2b_bin", 32'(bin), 32'(eb));
            check("b2b_hiba", 32'(hiba), 32'(eh));
            if (j > 0) check("b2b_period", 32'(cyc - last_ready_cyc), 32'd5);
            last_ready_cyc = cyc;
            @(posedge clk);
            #1;
            check("b2b_ready_low", 32'(ready), 32'd0);
            last_bin  = eb;
            last_hiba = eh;
        end
        start = 1'b0;
        @(posedge clk);
        #1;

        // Reset during the second conversion cycle aborts without a ready strobe.
        convert("pre_abort", 4'd1, 4'd9, 4'd8);
        din2  = 4'd4;
        din1  = 4'd5;
        din0  = 4'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_bin", 32'(bin), 32'd0);
        check("abort_hiba", 32'(hiba), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        saw = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ready) saw = 1'b1;
        end
        check("abort_no_ready", 32'(saw), 32'd0);
        last_bin  = '0;
        last_hiba = 1'b0;
        convert("post_abort", 4'd0, 4'd4, 4'd2);

        for (int k = 0; k < 24; k++) begin
            h = rand_digit();
            t = rand_digit();
            o = rand_digit();
            convert($sformatf("rand%0d", k), h, t, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
